// File: rtl/sw_led_debounce.sv
// ---------------------------------------------------------------------------
// sw_led_debounce
//
// Switch-to-LED front end for the DE2 board. Each raw slide switch is
// synchronised (2 flops), debounced (a level is accepted only after it has
// differed from the stable level for DB_CNT consecutive cycles) and drives
// one red LED. Two extra LEDs show "all switches equal" and "all switches
// on". Clean levels and rising-edge pulses are exported downstream.
//
// Optional feature macro: SW_LED_TOGGLE_EN
//   defined     : mode=1 makes each channel LED flip on every accepted rising
//                 edge; mode=0 makes it follow the switch level.
//   not defined : mode is ignored and channel LEDs always follow the switch.
//
// Parameters
//   NUM_SW  number of switch channels (>= 1)
//   DB_CNT  stable cycles needed to accept a new level (>= 2)
//   CNT_W   debounce counter width, 2**CNT_W >= DB_CNT
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   sw       in   [NUM_SW]    raw switches, asynchronous to clk
//   mode     in   1           0 = level mode, 1 = toggle mode
//   led_red  out  [NUM_SW+2]  [NUM_SW-1:0] channel LEDs, [NUM_SW] all-equal,
//                             [NUM_SW+1] all-on (registered)
//   sw_db    out  [NUM_SW]    debounced switch levels (registered)
//   sw_rise  out  [NUM_SW]    one-cycle pulse when sw_db rises (registered)
// ---------------------------------------------------------------------------
module sw_led_debounce #(
    parameter int unsigned NUM_SW = 2,
    parameter int unsigned DB_CNT = 1000000,
    parameter int unsigned CNT_W  = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] sw,
    input  logic              mode,
    output logic [NUM_SW+1:0] led_red,
    output logic [NUM_SW-1:0] sw_db,
    output logic [NUM_SW-1:0] sw_rise
);

    // Last count value before a differing level is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

    logic [NUM_SW-1:0] r_s1;
    logic [NUM_SW-1:0] r_s2;
    logic [CNT_W-1:0]  r_cnt [NUM_SW];
    logic [NUM_SW-1:0] r_db;
    logic [NUM_SW-1:0] r_rise;
    logic [NUM_SW+1:0] r_led;

    logic [NUM_SW-1:0] w_diff;
    logic [NUM_SW-1:0] w_done;
    logic [NUM_SW-1:0] w_led_ch;
    logic              w_all_eq;
    logic              w_all_on;

    // Two-flop synchroniser for the asynchronous switch pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= sw;
            r_s2 <= r_s1;
        end
    end

    // Per-channel compare: differing from the stable level, and whether this
    // is the DB_CNT-th consecutive differing cycle.
    always_comb begin
        w_diff = '0;
        w_done = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            w_diff[i] = r_s2[i] ^ r_db[i];
            w_done[i] = w_diff[i] && (r_cnt[i] == CNT_LAST);
        end
    end

    // Debounce counters, stable levels and rising-edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SW; i++) begin
                r_cnt[i] <= '0;
            end
            r_db   <= '0;
            r_rise <= '0;
        end else begin
            for (int i = 0; i < NUM_SW; i++) begin
                // Counter saturates by construction: it clears on acceptance.
                if (!w_diff[i] || w_done[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
            // An accepted channel always differs, so flipping it loads s2.
            r_db   <= r_db ^ w_done;
            r_rise <= w_done & r_s2;
        end
    end

`ifdef SW_LED_TOGGLE_EN
    logic [NUM_SW-1:0] r_tgl;

    // Tracks the level in level mode so entering toggle mode causes no jump.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tgl <= '0;
        end else if (mode) begin
            r_tgl <= r_tgl ^ r_rise;
        end else begin
            r_tgl <= r_db;
        end
    end

    assign w_led_ch = mode ? r_tgl : r_db;
`else
    logic w_unused_mode;

    assign w_unused_mode = mode;
    assign w_led_ch      = r_db;
`endif

    // Aggregate indicators from the debounced levels.
    assign w_all_on = &r_db;
    assign w_all_eq = w_all_on | ~(|r_db);

    // LED output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= '0;
        end else begin
            r_led <= {w_all_on, w_all_eq, w_led_ch};
        end
    end

    assign led_red = r_led;
    assign sw_db   = r_db;
    assign sw_rise = r_rise;

endmodule

// File: tb/tb_sw_led_debounce.sv
// ---------------------------------------------------------------------------
// tb_sw_led_debounce
//
// Directed bench for sw_led_debounce with NUM_SW=2, DB_CNT=4. Expected
// outputs are queued against an edge number (edges counted from the latest
// reset release) and compared #1 after that edge. Expectations for the
// channel LEDs depend on whether SW_LED_TOGGLE_EN is defined.
// ---------------------------------------------------------------------------
module tb_sw_led_debounce;

    localparam int unsigned NUM_SW = 2;
    localparam int unsigned DB_CNT = 4;
    localparam int unsigned CNT_W  = 3;

    logic              clk;
    logic              rst_n;
    logic [NUM_SW-1:0] sw;
    logic              mode;
    logic [NUM_SW+1:0] led_red;
    logic [NUM_SW-1:0] sw_db;
    logic [NUM_SW-1:0] sw_rise;

    sw_led_debounce #(
        .NUM_SW (NUM_SW),
        .DB_CNT (DB_CNT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw      (sw),
        .mode    (mode),
        .led_red (led_red),
        .sw_db   (sw_db),
        .sw_rise (sw_rise)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned at;
        string       tag;
        logic [3:0]  led;
        logic [1:0]  db;
        logic [1:0]  rise;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned ecount;
    int unsigned n_checks;
    int unsigned n_pass;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic push_exp(input int unsigned at, input string tag,
                            input logic [3:0] led, input logic [1:0] db,
                            input logic [1:0] rise);
        exp_t e;
        e.at   = at;
        e.tag  = tag;
        e.led  = led;
        e.db   = db;
        e.rise = rise;
        sb_q.push_back(e);
    endtask

    // One clock edge, then compare everything scheduled for this edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        ecount++;
        while (sb_q.size() > 0 && sb_q[0].at == ecount) begin
            e = sb_q.pop_front();
            chk({e.tag, "_led"},  32'(led_red), 32'(e.led));
            chk({e.tag, "_db"},   32'(sw_db),   32'(e.db));
            chk({e.tag, "_rise"}, 32'(sw_rise), 32'(e.rise));
        end
    endtask

    task automatic run_to(input int unsigned n);
        while (ecount < n) tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        ecount   = 0;
        rst_n    = 1'b0;
        sw       = 2'b11;
        mode     = 1'b0;

        // Reset holds everything at zero even with switches on.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led",  32'(led_red), 32'h0);
        chk("rst_db",   32'(sw_db),   32'h0);
        chk("rst_rise", 32'(sw_rise), 32'h0);

        sw     = 2'b00;
        rst_n  = 1'b1;
        ecount = 0;
        push_exp(1, "por", 4'b0100, 2'b00, 2'b00);
        tick();

        // Level accept: sampled at edge 2, accepted at edge 7, LED at 8.
        sw = 2'b01;
        push_exp(6, "lvl_pre", 4'b0100, 2'b00, 2'b00);
        push_exp(7, "lvl_acc", 4'b0100, 2'b01, 2'b01);
        push_exp(8, "lvl_led", 4'b0001, 2'b01, 2'b00);
        run_to(8);

        // Glitch on sw[1] lasting DB_CNT-1 cycles is discarded.
        for (int c = 9; c <= 16; c++) begin
            push_exp(c, "glitch", 4'b0001, 2'b01, 2'b00);
        end
        sw = 2'b11;
        run_to(11);
        sw = 2'b01;
        run_to(16);

        // Both switches on.
        sw = 2'b11;
        push_exp(21, "both_pre", 4'b0001, 2'b01, 2'b00);
        push_exp(22, "both_acc", 4'b0001, 2'b11, 2'b10);
        push_exp(23, "both_led", 4'b1111, 2'b11, 2'b00);
        run_to(23);

        // Both off: no rise pulse on falling acceptance.
        sw = 2'b00;
        push_exp(29, "clr_acc", 4'b1111, 2'b00, 2'b00);
        push_exp(30, "clr_led", 4'b0100, 2'b00, 2'b00);
        run_to(30);

        // Toggle-mode sequence: sw[0] high 8, low 8, high 8 cycles.
`ifdef SW_LED_TOGGLE_EN
        push_exp(31, "tg_mode", 4'b0100, 2'b00, 2'b00);
        push_exp(36, "tg_acc1", 4'b0100, 2'b01, 2'b01);
        push_exp(37, "tg_agg1", 4'b0000, 2'b01, 2'b00);
        push_exp(38, "tg_on",   4'b0001, 2'b01, 2'b00);
        push_exp(45, "tg_hold", 4'b0101, 2'b00, 2'b00);
        push_exp(52, "tg_acc2", 4'b0101, 2'b01, 2'b01);
        push_exp(53, "tg_agg2", 4'b0001, 2'b01, 2'b00);
        push_exp(54, "tg_off",  4'b0000, 2'b01, 2'b00);
        push_exp(55, "tg_lvl",  4'b0001, 2'b01, 2'b00);
`else
        push_exp(31, "tg_mode", 4'b0100, 2'b00, 2'b00);
        push_exp(36, "tg_acc1", 4'b0100, 2'b01, 2'b01);
        push_exp(37, "tg_agg1", 4'b0001, 2'b01, 2'b00);
        push_exp(38, "tg_on",   4'b0001, 2'b01, 2'b00);
        push_exp(45, "tg_hold", 4'b0100, 2'b00, 2'b00);
        push_exp(52, "tg_acc2", 4'b0100, 2'b01, 2'b01);
        push_exp(53, "tg_agg2", 4'b0001, 2'b01, 2'b00);
        push_exp(54, "tg_off",  4'b0001, 2'b01, 2'b00);
        push_exp(55, "tg_lvl",  4'b0001, 2'b01, 2'b00);
`endif
        mode = 1'b1;
        sw   = 2'b01;
        run_to(38);
        sw = 2'b00;
        run_to(46);
        sw = 2'b01;
        run_to(54);
        mode = 1'b0;
        run_to(55);

        // Fall back to 00 before the mid-count reset test.
        sw = 2'b00;
        push_exp(61, "fall_acc", 4'b0001, 2'b00, 2'b00);
        push_exp(62, "fall_led", 4'b0100, 2'b00, 2'b00);
        run_to(62);

        // Reset after three counted cycles of a rising sw[0].
        sw = 2'b01;
        run_to(66);
        rst_n = 1'b0;
        #1;
        chk("rstmid_led",  32'(led_red), 32'h0);
        chk("rstmid_db",   32'(sw_db),   32'h0);
        chk("rstmid_rise", 32'(sw_rise), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        ecount = 0;
        push_exp(1, "rel",     4'b0100, 2'b00, 2'b00);
        push_exp(5, "rel_pre", 4'b0100, 2'b00, 2'b00);
        push_exp(6, "rel_acc", 4'b0100, 2'b01, 2'b01);
        push_exp(7, "rel_led", 4'b0001, 2'b01, 2'b00);
        run_to(7);

        chk("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sw_led_debounce.md
# sw_led_debounce

Parametrised switch-to-LED front end for the DE2 board. It synchronises and debounces NUM_SW slide switches, drives one red LED per switch, and adds two aggregate indicator LEDs: "all switches equal" and "all switches on". Per-channel LEDs run in level mode (LED follows the switch) or toggle mode (each switch rising edge flips the LED). It sits directly between the board switch pins and the LED pins and also exports clean switch levels and edge pulses to downstream logic.

## Interface
- NUM_SW, 2, number of switch channels (min 1)
- DB_CNT, 1000000, stable cycles required to accept a new level (20 ms at 50 MHz; min 2)
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W >= DB_CNT
- clk  in  1  system clock (50 MHz on board)
- rst_n  in  1  asynchronous active-low reset
- sw  in  NUM_SW  raw switch inputs, asynchronous to clk
- mode  in  1  0 = level mode, 1 = toggle mode (synchronous to clk)
- led_red  out  NUM_SW+2  [NUM_SW-1:0] per-channel LEDs, [NUM_SW] all-equal, [NUM_SW+1] all-on; registered
- sw_db  out  NUM_SW  debounced switch levels
- sw_rise  out  NUM_SW  one-cycle pulse per channel when sw_db rises

## Operation
- Per channel: 2-flop synchroniser sw -> s1 -> s2, then debounce counter and stable register (sw_db).
- Counter: if s2 != sw_db, increment; if count == DB_CNT-1 and still differing, sw_db <= s2, count <= 0. If s2 == sw_db, count <= 0. Any glitch shorter than DB_CNT cycles is discarded.
- sw_rise[i] = 1 for exactly the cycle in which sw_db[i] first reads 1 after a 0->1 acceptance; 0 otherwise.
- Toggle register tgl[i]: mode=0 -> tgl <= sw_db (tracks, so entering toggle mode causes no jump); mode=1 -> tgl[i] <= ~tgl[i] on sw_rise[i].
- led_red[i] <= mode ? tgl[i] : sw_db[i].
- led_red[NUM_SW] <= 1 when all sw_db bits equal (all 0 or all 1), else 0.
- led_red[NUM_SW+1] <= &sw_db.
- Mode change takes effect on led_red the next edge; in-progress debounce counts are unaffected.

## Timing
- Reset (rst_n low, asynchronous): s1, s2, counters, sw_db, sw_rise, tgl, led_red all 0.
- First clk edge after rst_n release: led_red[NUM_SW] = 1 (all channels equal at 0), other bits 0.
- Latency: new sw level sampled at edge k -> s2 at k+1 -> sw_db and sw_rise at edge k+1+DB_CNT -> led_red at edge k+2+DB_CNT (count edge k as 1: DB_CNT+3 edges in total from first sample to LED).
- sw_rise width exactly 1 cycle; no pulse on 1->0 acceptance.
- Simultaneous changes on several channels: channels independent; aggregate LEDs update on the edge after the last channel accepts.
- Reset mid-count: counter cleared immediately; no acceptance occurs after release without a fresh full DB_CNT interval.
- Counter never exceeds DB_CNT-1; no wrap-around.

## Configuration
- SW_LED_TOGGLE_EN defined: toggle registers and mode behaviour compiled in as above.
- Not defined: mode port still present but ignored; tgl logic removed; led_red[NUM_SW-1:0] always follows sw_db (level mode only). All other behaviour identical.

## Test plan
- Bench parameters NUM_SW=2, DB_CNT=4, SW_LED_TOGGLE_EN defined unless stated.
- Reset: rst_n low with sw=2'b11 -> all outputs 0; release with sw=00 -> led_red=4'b0100 after first edge.
- Level accept: sw=2'b01 held from edge 1 -> sw_db=01, sw_rise=01 for one cycle at edge 6; led_red=4'b0001 at edge 7.
- Glitch reject: sw[1] high for 3 cycles then low -> sw_db, sw_rise, led_red unchanged; then sw=11 held -> led_red=4'b1111.
- Toggle: mode=1, sw[0] high 8 cycles, low 8, high 8 -> led_red[0] goes 1, stays 1, goes 0; led_red[3:2] follow sw_db; mode=0 -> led_red[0]=sw_db[0] next edge.
- Reset mid-count: sw=01, assert rst_n at cycle 3 of count for 2 cycles -> outputs 0 immediately; after release full DB_CNT+3 edges needed before led_red[0]=1.
- Macro off: mode=1 with sw[0] pulses -> led_red[0] tracks sw_db[0] (no toggling).
